// File: rtl/gcn_sequencer_pkg.sv
// Shared types and defaults for the GCN frame sequencer.
package gcn_sequencer_pkg;

  // Default frame geometry
  localparam int unsigned N_WORDS_DEF = 2512;
  localparam int unsigned N_ROWS_DEF  = 100;
  localparam int unsigned AW_DEF      = 12;

  // Word tags carried on i_cmd / wr_cmd
  localparam logic TAG_CMD  = 1'b1;
  localparam logic TAG_DATA = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompute,
    StWait,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/gcn_seq_counter.sv
// Loadable up-counter with a terminal-count flag at a fixed value TC.
module gcn_seq_counter #(
  parameter int unsigned W  = 8,
  parameter int unsigned TC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == W'(TC));

endmodule

// File: rtl/gcn_sequencer.sv
// Frame sequencer: loads words into memory, kicks the PE array, then drains results.
module gcn_sequencer
  import gcn_sequencer_pkg::*;
#(
  parameter int unsigned N_WORDS = N_WORDS_DEF,
  parameter int unsigned N_ROWS  = N_ROWS_DEF,
  parameter int unsigned AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_cmd,
  input  logic [15:0]   i_data,
  input  logic          mem_busy,
  input  logic          pe_done,
  input  logic [15:0]   rd_data,
  output logic          wr_en,
  output logic          wr_cmd,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          pe_start,
  output logic [15:0]   cfg_cols,
  output logic          rd_en,
  output logic [7:0]    rd_addr,
  output logic          o_rdy,
  output logic          o_result,
  output logic [15:0]   o_data
);

  localparam int unsigned DW = $clog2(2 * N_ROWS + 1);

  seq_state_e    r_state;
  logic          r_wr_en;
  logic          r_wr_cmd;
  logic [AW-1:0] r_wr_addr;
  logic [15:0]   r_wr_data;
  logic          r_pe_start;
  logic [15:0]   r_cfg_cols;
  logic          r_cmd_seen;

  logic          w_accept;
  logic          w_last;
  logic [AW-1:0] w_word_cnt;
  logic          w_word_tc;
  logic [AW-1:0] w_idx;
  logic [DW-1:0] w_drain_cnt;
  logic          w_drain_tc;

  assign w_accept = ((r_state == StIdle && i_req) || r_state == StLoad) && !mem_busy;
  // Word 0 is taken in IDLE, so the counter already holds the next index while in LOAD
  assign w_idx    = (r_state == StIdle) ? '0 : w_word_cnt;
  assign w_last   = (r_state == StIdle) ? (N_WORDS == 1) : w_word_tc;

  gcn_seq_counter #(
    .W  (AW),
    .TC (N_WORDS - 1)
  ) u_word_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && r_state == StIdle),
    .i_load_val (AW'(1)),
    .i_inc      (w_accept && r_state == StLoad),
    .o_count    (w_word_cnt),
    .o_tc       (w_word_tc)
  );

  gcn_seq_counter #(
    .W  (DW),
    .TC (2 * N_ROWS)
  ) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == StWait && pe_done),
    .i_load_val ('0),
    .i_inc      (r_state == StDrain && !w_drain_tc),
    .o_count    (w_drain_cnt),
    .o_tc       (w_drain_tc)
  );

  // Main FSM with registered write strobe, compute pulse and column select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wr_en    <= 1'b0;
      r_wr_cmd   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_pe_start <= 1'b0;
      r_cfg_cols <= '0;
      r_cmd_seen <= 1'b0;
    end else begin
      r_wr_en    <= w_accept;
      r_wr_cmd   <= w_accept ? i_cmd : 1'b0;
      r_wr_addr  <= w_accept ? w_idx : '0;
      r_wr_data  <= w_accept ? i_data : '0;
      r_pe_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            // Frame start clears the column select before the first command word lands
            r_cfg_cols <= (i_cmd == TAG_CMD) ? i_data : '0;
            r_cmd_seen <= (i_cmd == TAG_CMD);
            if (w_last) begin
              r_state    <= StCompute;
              r_pe_start <= 1'b1;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StLoad: begin
          if (w_accept) begin
            if (i_cmd == TAG_CMD && !r_cmd_seen) begin
              r_cfg_cols <= i_data;
              r_cmd_seen <= 1'b1;
            end
            if (w_last) begin
              r_state    <= StCompute;
              r_pe_start <= 1'b1;
            end
          end
        end
        StCompute: r_state <= StWait;
        StWait: begin
          if (pe_done) r_state <= StDrain;
        end
        StDrain: begin
          if (w_drain_tc) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Drain-phase read strobe, output stream and handshake qualifier
  always_comb begin
    o_rdy    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    o_data   = '0;
    o_result = 1'b1;
    unique case (r_state)
      StIdle, StLoad: o_result = mem_busy;
      StDrain: begin
        o_result = 1'b0;
        o_rdy    = 1'b1;
        rd_en    = !w_drain_tc;
        rd_addr  = w_drain_tc ? 8'd0 : 8'(w_drain_cnt);
        // Header word first; afterwards the 1-cycle-latency read data passes straight out
        o_data   = (w_drain_cnt == '0) ? r_cfg_cols : rd_data;
      end
      default: o_result = 1'b1;
    endcase
  end

  assign wr_en    = r_wr_en;
  assign wr_cmd   = r_wr_cmd;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign pe_start = r_pe_start;
  assign cfg_cols = r_cfg_cols;

endmodule

// File: doc/gcn_sequencer.md
GCN_SEQUENCER -- requirements
Module: gcn_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_WORDS, 2512, input words per frame.
- N_ROWS, 100, result rows per output column.
- AW, 12, word-memory address width; 2^AW >= N_WORDS.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- i_req, in, 1, frame-start request.
- i_cmd, in, 1, word tag: 1 = command word, 0 = data word.
- i_data, in, 16, input word.
- mem_busy, in, 1, word memory cannot accept a write this cycle.
- pe_done, in, 1, one-cycle pulse: PE array finished.
- rd_data, in, 16, result memory read data, 1-cycle latency.
- wr_en, out, 1, word memory write strobe.
- wr_cmd, out, 1, tag of the word being written.
- wr_addr, out, AW, write address.
- wr_data, out, 16, write data.
- pe_start, out, 1, one-cycle compute start pulse.
- cfg_cols, out, 16, latched column select {col2, col1}.
- rd_en, out, 1, result read strobe.
- rd_addr, out, 8, result read address.
- o_rdy, out, 1, output phase active.
- o_result, out, 1, active-low qualifier: in LOAD, 0 = word accepted; in DRAIN, 0 = o_data valid.
- o_data, out, 16, output word.

Function
REQ-003 States: IDLE, LOAD, COMPUTE, WAIT, DRAIN; the encoding is private to the block.
REQ-004 Word acceptance: a word is accepted on a cycle where (IDLE and i_req=1) or (LOAD), and mem_busy=0.
REQ-005 o_result SHALL equal mem_busy in IDLE and LOAD (combinational); o_result SHALL be 0 in DRAIN and 1 in COMPUTE and WAIT.
REQ-006 IDLE -> LOAD on the first accepted word; if mem_busy=1 while i_req=1, the block stays in IDLE and takes no word.
REQ-007 Word counter: starts at 0 on entry from IDLE and increments by 1 per accepted word. The Nth accepted word moves the block to COMPUTE; the counter never wraps.
REQ-008 Write timing: each accepted word produces wr_en=1 on the next cycle, with wr_addr = word index, wr_data = i_data and wr_cmd = i_cmd.
REQ-009 Column select: cfg_cols latches the first i_cmd=1 word of the frame; later command words are written to memory but do not update cfg_cols. cfg_cols is cleared to 0 on each frame start.
REQ-010 i_req is ignored outside IDLE.
REQ-011 COMPUTE lasts exactly 1 cycle, with pe_start=1, then moves to WAIT.
REQ-012 WAIT -> DRAIN on pe_done=1; pe_done is ignored in every other state.
REQ-013 DRAIN lasts exactly 1+2*N_ROWS cycles, with o_rdy=1 throughout.
- Cycle 0: o_data = cfg_cols.
- Cycles 1..2*N_ROWS: o_data = rd_data.
- rd_en=1 with rd_addr k on drain cycles k = 0..2*N_ROWS-1.
- Order: all col1 rows (addresses 0..N_ROWS-1), then all col2 rows.
REQ-014 After the last DRAIN cycle the block returns to IDLE, with o_rdy=0 on the next cycle.
REQ-015 Outputs not defined by the current state SHALL be 0.

Reset
REQ-016 rst=1 immediately forces:
- state = IDLE;
- all counters = 0, cfg_cols = 0;
- wr_en, pe_start, rd_en, o_rdy, o_data = 0.
REQ-017 Reset mid-frame discards the partial frame; no write or read strobe occurs after rst asserts.
REQ-018 The first frame may start on the first clk edge after rst deasserts.

Structure
REQ-019 A shared package holds the state enum, the N_WORDS, N_ROWS and AW defaults, and the command/data tag constants.
REQ-020 One sub-module, gcn_seq_counter (a loadable up-counter with terminal-count flag), is instantiated for the word count and the drain count.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Nominal frame: N_WORDS=8, N_ROWS=2, word 0 = cmd 0x0301, mem_busy=0 -> 8 writes at addresses 0..7; pe_start 1 cycle after word 7; after pe_done, 5 DRAIN cycles with outputs 0x0301, then rd_data[0..3].
- Back-pressure: mem_busy=1 on cycles 3-4 of LOAD -> o_result=1 on those cycles, no writes; all 8 addresses still written exactly once.
- No command word: frame carries only data words -> cfg_cols=0 and header word 0x0000.
- Stray pulses: pe_done during LOAD and i_req during DRAIN -> no state change, output stream unchanged.
- Reset mid-LOAD after 5 words -> wr_en=0 immediately; the next frame writes from address 0.
- Back-to-back: i_req on the cycle after DRAIN ends -> the new frame is accepted with no extra idle cycles.
